// File: rtl/uart_block_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : uart_block_bridge
//  Purpose  : Width adapter between a byte-wide UART pair and a 64-bit block
//             datapath. The receive side packs eight bytes (big-endian, first
//             byte in [63:56]) into a block offered on a valid/ready output and
//             drops a partial block after an idle timeout. The transmit side
//             accepts a 64-bit block and feeds uart_send one byte at a time
//             through its start / tx_rdy handshake.
//  Ports    : clk, rst (async, active low)
//             rx_byte/rx_done                  <- uart_recv
//             blk_out/blk_out_valid/blk_out_ready -> block consumer
//             blk_in/blk_in_valid/blk_in_ready    <- block producer
//             tx_byte/tx_start/tx_rdy          <-> uart_send
//             rx_overrun/rx_timeout (sticky), err_clr (sync clear)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_block_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 10416 * 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_byte,
   input  logic        rx_done,
   output logic [63:0] blk_out,
   output logic        blk_out_valid,
   input  logic        blk_out_ready,
   input  logic [63:0] blk_in,
   input  logic        blk_in_valid,
   output logic        blk_in_ready,
   output logic [7:0]  tx_byte,
   output logic        tx_start,
   input  logic        tx_rdy,
   output logic        rx_overrun,
   output logic        rx_timeout,
   input  logic        err_clr
);

   localparam logic [31:0] IDLE_LIMIT = 32'(TIMEOUT_CYCLES - 1);

   // ------------------------------------------------------------------------
   // Receive assembler
   // ------------------------------------------------------------------------
   logic [2:0]  rx_cnt_q,        rx_cnt_d;
   logic [55:0] asm_q,           asm_d;
   logic [31:0] idle_q,          idle_d;
   logic [63:0] blk_out_q,       blk_out_d;
   logic        blk_out_valid_q, blk_out_valid_d;
   logic        rx_overrun_q,    rx_overrun_d;
   logic        rx_timeout_q,    rx_timeout_d;
   logic        out_free;

   // The output register may be reloaded in the same cycle it is consumed.
   assign out_free = !blk_out_valid_q || blk_out_ready;

   always_comb begin
      rx_cnt_d        = rx_cnt_q;
      asm_d           = asm_q;
      idle_d          = idle_q;
      blk_out_d       = blk_out_q;
      blk_out_valid_d = blk_out_valid_q;
      // Clear first so that a set event in the same cycle wins.
      rx_overrun_d    = rx_overrun_q & ~err_clr;
      rx_timeout_d    = rx_timeout_q & ~err_clr;

      if (blk_out_valid_q && blk_out_ready) begin
         blk_out_valid_d = 1'b0;
      end

      if (rx_done) begin
         // A byte always beats a timeout landing in the same cycle.
         idle_d = '0;
         if (rx_cnt_q != 3'd7) begin
            asm_d    = {asm_q[47:0], rx_byte};
            rx_cnt_d = rx_cnt_q + 3'd1;
         end else if (out_free) begin
            blk_out_d       = {asm_q, rx_byte};
            blk_out_valid_d = 1'b1;
            rx_cnt_d        = 3'd0;
         end else begin
            // Completing byte lost; keep the seven bytes already gathered.
            rx_overrun_d = 1'b1;
         end
      end else if (rx_cnt_q != 3'd0) begin
         if (idle_q == IDLE_LIMIT) begin
            rx_cnt_d     = 3'd0;
            idle_d       = '0;
            rx_timeout_d = 1'b1;
         end else begin
            idle_d = idle_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_cnt_q        <= '0;
         asm_q           <= '0;
         idle_q          <= '0;
         blk_out_q       <= '0;
         blk_out_valid_q <= 1'b0;
         rx_overrun_q    <= 1'b0;
         rx_timeout_q    <= 1'b0;
      end else begin
         rx_cnt_q        <= rx_cnt_d;
         asm_q           <= asm_d;
         idle_q          <= idle_d;
         blk_out_q       <= blk_out_d;
         blk_out_valid_q <= blk_out_valid_d;
         rx_overrun_q    <= rx_overrun_d;
         rx_timeout_q    <= rx_timeout_d;
      end
   end

   // ------------------------------------------------------------------------
   // Transmit serializer
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_LOAD = 2'd1,
      TX_ACK  = 2'd2,
      TX_WAIT = 2'd3
   } tx_state_t;

   tx_state_t   tx_state_q,     tx_state_d;
   logic [63:0] tx_sr_q,        tx_sr_d;
   logic [2:0]  tx_idx_q,       tx_idx_d;
   logic [7:0]  tx_byte_q,      tx_byte_d;
   logic        tx_start_q,     tx_start_d;
   logic        blk_in_ready_q, blk_in_ready_d;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_sr_d    = tx_sr_q;
      tx_idx_d   = tx_idx_q;
      tx_byte_d  = tx_byte_q;
      tx_start_d = 1'b0;

      case (tx_state_q)
         TX_IDLE: begin
            // blk_in_ready_q is low for the first cycle after reset release.
            if (blk_in_valid && blk_in_ready_q) begin
               tx_sr_d    = blk_in;
               tx_idx_d   = 3'd0;
               tx_byte_d  = blk_in[63:56];
               tx_state_d = TX_LOAD;
            end
         end
         TX_LOAD: begin
            if (tx_rdy) begin
               tx_start_d = 1'b1;
               tx_state_d = TX_ACK;
            end
         end
         TX_ACK: begin
            // Require tx_rdy low before looking for it high again, so every
            // start sees a fresh ready edge from uart_send.
            if (!tx_rdy) begin
               tx_state_d = TX_WAIT;
            end
         end
         TX_WAIT: begin
            if (tx_rdy) begin
               if (tx_idx_q == 3'd7) begin
                  tx_state_d = TX_IDLE;
               end else begin
                  tx_sr_d    = {tx_sr_q[55:0], 8'h00};
                  tx_idx_d   = tx_idx_q + 3'd1;
                  tx_byte_d  = tx_sr_q[55:48];
                  tx_state_d = TX_LOAD;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase

      blk_in_ready_d = (tx_state_d == TX_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state_q     <= TX_IDLE;
         tx_sr_q        <= '0;
         tx_idx_q       <= '0;
         tx_byte_q      <= '0;
         tx_start_q     <= 1'b0;
         blk_in_ready_q <= 1'b0;
      end else begin
         tx_state_q     <= tx_state_d;
         tx_sr_q        <= tx_sr_d;
         tx_idx_q       <= tx_idx_d;
         tx_byte_q      <= tx_byte_d;
         tx_start_q     <= tx_start_d;
         blk_in_ready_q <= blk_in_ready_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign blk_out       = blk_out_q;
   assign blk_out_valid = blk_out_valid_q;
   assign blk_in_ready  = blk_in_ready_q;
   assign tx_byte       = tx_byte_q;
   assign tx_start      = tx_start_q;
   assign rx_overrun    = rx_overrun_q;
   assign rx_timeout    = rx_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_block_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_block_bridge
//  Purpose  : Self-checking bench for uart_block_bridge. Receive traffic is
//             predicted by a queue-based byte/block model; transmit traffic
//             is checked against a behavioural uart_send (frame = 10 bit
//             times at DIVIDER 4) that also provides a tx->rx loopback.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_block_bridge;

   localparam int TMO   = 100;
   localparam int FRAME = 10 * 4;

   logic        clk;
   logic        rst;
   logic [7:0]  rx_byte;
   logic        rx_done;
   logic [63:0] blk_out;
   logic        blk_out_valid;
   logic        blk_out_ready;
   logic [63:0] blk_in;
   logic        blk_in_valid;
   logic        blk_in_ready;
   logic [7:0]  tx_byte;
   logic        tx_start;
   logic        tx_rdy;
   logic        rx_overrun;
   logic        rx_timeout;
   logic        err_clr;

   // Driver / loopback sources for the receive port
   logic        drv_done;
   logic [7:0]  drv_byte;
   logic        lb_done;
   logic [7:0]  lb_byte;
   logic        loop_en;

   assign rx_done = loop_en ? lb_done : drv_done;
   assign rx_byte = loop_en ? lb_byte : drv_byte;

   uart_block_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_byte       (rx_byte),
      .rx_done       (rx_done),
      .blk_out       (blk_out),
      .blk_out_valid (blk_out_valid),
      .blk_out_ready (blk_out_ready),
      .blk_in        (blk_in),
      .blk_in_valid  (blk_in_valid),
      .blk_in_ready  (blk_in_ready),
      .tx_byte       (tx_byte),
      .tx_start      (tx_start),
      .tx_rdy        (tx_rdy),
      .rx_overrun    (rx_overrun),
      .rx_timeout    (rx_timeout),
      .err_clr       (err_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ------------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------------
   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------------------------
   // uart_send behavioural model + loopback + protocol monitors
   // ------------------------------------------------------------------------
   logic [7:0] tx_got[$];
   int         fr_cnt;
   logic [7:0] cur_byte;
   logic       prev_start;
   int         start_err;
   int         hold_err;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_rdy     <= 1'b1;
         fr_cnt     <= 0;
         cur_byte   <= 8'h00;
         lb_done    <= 1'b0;
         lb_byte    <= 8'h00;
         prev_start <= 1'b0;
      end else begin
         prev_start <= tx_start;
         lb_done    <= 1'b0;
         if (tx_start && (prev_start || fr_cnt != 0))
            start_err <= start_err + 1;
         if (fr_cnt != 0) begin
            fr_cnt <= fr_cnt - 1;
            if (fr_cnt == 1) begin
               tx_rdy <= 1'b1;
               if (loop_en) begin
                  lb_done <= 1'b1;
                  lb_byte <= cur_byte;
               end
            end
         end else if (tx_start) begin
            tx_rdy   <= 1'b0;
            fr_cnt   <= FRAME;
            cur_byte <= tx_byte;
            tx_got.push_back(tx_byte);
         end
      end
   end

   // tx_byte must not move while uart_send is busy with it.
   always @(posedge clk) begin
      if (rst && !tx_rdy && tx_got.size() > 0 && tx_byte != tx_got[$])
         hold_err <= hold_err + 1;
   end

   // Blocks actually consumed from the DUT
   logic [63:0] got_q[$];
   always @(posedge clk) begin
      if (rst && blk_out_valid && blk_out_ready)
         got_q.push_back(blk_out);
   end

   // ------------------------------------------------------------------------
   // Receive reference model: a byte list per partial block
   // ------------------------------------------------------------------------
   logic [7:0]  part_q[$];
   logic [63:0] exp_q[$];
   int          idle_m;
   bit          slot_m;
   bit          ov_m;
   bit          to_m;
   int          sb_idx;

   task automatic model_rx(input logic done, input logic [7:0] b, input logic rdy, input logic clr);
      bit          free;
      logic [63:0] v;
      free = !slot_m || rdy;
      if (slot_m && rdy) slot_m = 0;
      if (clr) begin
         ov_m = 0;
         to_m = 0;
      end
      if (done) begin
         idle_m = 0;
         if (part_q.size() < 7) begin
            part_q.push_back(b);
         end else if (free) begin
            v = 64'd0;
            foreach (part_q[i]) v = (v << 8) | 64'(part_q[i]);
            v = (v << 8) | 64'(b);
            exp_q.push_back(v);
            slot_m = 1;
            part_q.delete();
         end else begin
            ov_m = 1;
         end
      end else if (part_q.size() != 0) begin
         idle_m++;
         if (idle_m == TMO) begin
            part_q.delete();
            idle_m = 0;
            to_m   = 1;
         end
      end
   endtask

   task automatic step(input logic done, input logic [7:0] b, input logic clr);
      drv_done = done;
      drv_byte = b;
      err_clr  = clr;
      model_rx(done, b, blk_out_ready, clr);
      @(posedge clk);
      #1;
      drv_done = 1'b0;
      err_clr  = 1'b0;
   endtask

   task automatic sb_drain(input string tag);
      check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      while (sb_idx < got_q.size() && sb_idx < exp_q.size()) begin
         check(tag, got_q[sb_idx], exp_q[sb_idx]);
         sb_idx++;
      end
   endtask

   task automatic send_blk(input logic [63:0] v);
      int base;
      bit done;
      bit rdy_early;
      blk_out_ready = 1'b1;
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (blk_in_ready) done = 1;
         else step(1'b0, 8'h00, 1'b0);
      end
      check("tx_accept_wait", 64'(done), 64'd1);
      base         = tx_got.size();
      blk_in       = v;
      blk_in_valid = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      blk_in_valid = 1'b0;
      check("tx_ready_low", 64'(blk_in_ready), 64'd0);
      done      = 0;
      rdy_early = 0;
      for (int i = 0; i < 4000 && !done; i++) begin
         step(1'b0, 8'h00, 1'b0);
         if (blk_in_ready) begin
            done = 1;
            if (tx_got.size() - base != 8) rdy_early = 1;
         end
      end
      check("tx_done", 64'(done), 64'd1);
      check("tx_ready_early", 64'(rdy_early), 64'd0);
      repeat (5) step(1'b0, 8'h00, 1'b0);
      check("tx_nbytes", 64'(tx_got.size() - base), 64'd8);
      for (int i = 0; i < 8; i++) begin
         if (base + i < tx_got.size())
            check("tx_byte", 64'(tx_got[base+i]), (v >> (8 * (7 - i))) & 64'hFF);
      end
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          base;
      bit          done;
      logic [63:0] v;
      start_err     = 0;
      hold_err      = 0;
      sb_idx        = 0;
      idle_m        = 0;
      slot_m        = 0;
      ov_m          = 0;
      to_m          = 0;
      loop_en       = 1'b0;
      drv_done      = 1'b0;
      drv_byte      = 8'h00;
      err_clr       = 1'b0;
      blk_out_ready = 1'b1;
      blk_in        = '0;
      blk_in_valid  = 1'b0;
      rst           = 1'b1;
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_blk_out", blk_out, 64'd0);
      check("rst_ctrl", 64'({blk_out_valid, blk_in_ready, tx_byte, tx_start, rx_overrun, rx_timeout}), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      #1 check("ready_before_edge", 64'(blk_in_ready), 64'd0);
      @(posedge clk);
      #1 check("ready_after_edge", 64'(blk_in_ready), 64'd1);

      // Basic block, consumer always ready
      for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
      check("blk1", blk_out, 64'h0102030405060708);
      check("blk1_valid", 64'(blk_out_valid), 64'd1);
      check("blk1_flags", 64'({rx_overrun, rx_timeout}), 64'd0);
      step(1'b0, 8'h00, 1'b0);
      check("blk1_valid_drop", 64'(blk_out_valid), 64'd0);
      sb_drain("sb_blk1");

      // Overrun with consumer stalled
      blk_out_ready = 1'b0;
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
      check("ovr_hold", blk_out, 64'h0001020304050607);
      check("ovr_valid", 64'(blk_out_valid), 64'd1);
      check("ovr_flag", 64'(rx_overrun), 64'(ov_m));
      blk_out_ready = 1'b1;
      step(1'b1, 8'hAA, 1'b0);
      check("ovr_next", blk_out, 64'h08090A0B0C0D0EAA);
      step(1'b0, 8'h00, 1'b0);
      sb_drain("sb_ovr");
      step(1'b0, 8'h00, 1'b1);
      check("ovr_clr", 64'(rx_overrun), 64'd0);

      // Timeout: exactly TMO silent cycles drop the partial block
      step(1'b1, 8'h11, 1'b0);
      step(1'b1, 8'h22, 1'b0);
      step(1'b1, 8'h33, 1'b0);
      repeat (TMO - 1) step(1'b0, 8'h00, 1'b0);
      check("tmo_early", 64'(rx_timeout), 64'd0);
      step(1'b0, 8'h00, 1'b0);
      check("tmo_set", 64'(rx_timeout), 64'd1);
      check("tmo_model", 64'(rx_timeout), 64'(to_m));
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
      check("tmo_blk", blk_out, 64'hA0A1A2A3A4A5A6A7);
      step(1'b0, 8'h00, 1'b1);
      check("tmo_clr", 64'(rx_timeout), 64'd0);

      // Boundary: a byte arriving on the timeout cycle wins
      step(1'b1, 8'h51, 1'b0);
      step(1'b1, 8'h52, 1'b0);
      step(1'b1, 8'h53, 1'b0);
      repeat (TMO - 1) step(1'b0, 8'h00, 1'b0);
      for (int i = 4; i <= 8; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
      check("tmo_edge_blk", blk_out, 64'h5152535455565758);
      check("tmo_edge_flag", 64'(rx_timeout), 64'd0);
      step(1'b0, 8'h00, 1'b0);
      sb_drain("sb_tmo");

      // Randomised receive with a randomly stalling consumer
      for (int k = 0; k < 48; k++) begin
         int gap;
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) begin
            blk_out_ready = 1'($urandom_range(0, 1));
            step(1'b0, 8'h00, 1'b0);
         end
         blk_out_ready = 1'($urandom_range(0, 1));
         step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      end
      blk_out_ready = 1'b1;
      repeat (TMO + 10) step(1'b0, 8'h00, 1'b0);
      sb_drain("sb_rand");
      check("rand_ovr", 64'(rx_overrun), 64'(ov_m));
      check("rand_tmo", 64'(rx_timeout), 64'(to_m));
      step(1'b0, 8'h00, 1'b1);
      check("rand_clr", 64'({rx_overrun, rx_timeout}), 64'd0);

      // Transmit
      send_blk(64'hDEADBEEF01234567);
      for (int k = 0; k < 2; k++) send_blk({$urandom, $urandom});

      // Loopback tx -> rx
      loop_en = 1'b1;
      exp_q.push_back(64'h0123456789ABCDEF);
      send_blk(64'h0123456789ABCDEF);
      repeat (5) step(1'b0, 8'h00, 1'b0);
      loop_en = 1'b0;
      sb_drain("sb_loop");
      check("loop_flags", 64'({rx_overrun, rx_timeout}), 64'd0);

      // Reset during the 4th transmitted byte, after the 5th received byte
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (blk_in_ready) done = 1;
         else step(1'b0, 8'h00, 1'b0);
      end
      base         = tx_got.size();
      blk_in       = 64'h1122334455667788;
      blk_in_valid = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      blk_in_valid = 1'b0;
      done = 0;
      for (int i = 0; i < 1000 && !done; i++) begin
         if (tx_got.size() - base >= 4) done = 1;
         else step(1'b0, 8'h00, 1'b0);
      end
      check("rst_reach_byte4", 64'(done), 64'd1);
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
      #3 rst = 1'b0;
      #1;
      check("mid_rst_blk_out", blk_out, 64'd0);
      check("mid_rst_ctrl", 64'({blk_out_valid, blk_in_ready, tx_byte, tx_start, rx_overrun, rx_timeout}), 64'd0);
      part_q.delete();
      idle_m = 0;
      slot_m = 0;
      ov_m   = 0;
      to_m   = 0;
      @(negedge clk);
      rst = 1'b1;
      #1 check("rel_ready_low", 64'(blk_in_ready), 64'd0);
      @(posedge clk);
      #1 check("rel_ready_high", 64'(blk_in_ready), 64'd1);
      repeat (60) step(1'b0, 8'h00, 1'b0);
      check("rst_tx_abandon", 64'(tx_got.size() - base), 64'd4);
      for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      v = exp_q[$];
      check("rst_fresh_blk", blk_out, v);
      step(1'b0, 8'h00, 1'b0);
      sb_drain("sb_rst");
      send_blk({$urandom, $urandom});

      check("tx_start_protocol", 64'(start_err), 64'd0);
      check("tx_byte_hold", 64'(hold_err), 64'd0);
      check("final_flags", 64'({rx_overrun, rx_timeout}), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_block_bridge.md
# uart_block_bridge

Width adapter between the byte-wide UART pair (`uart_recv` / `uart_send`) and the 64-bit TEA datapath. The receive side packs eight `rx_done` bytes into one 64-bit block and offers it on a valid/ready output. The transmit side accepts a 64-bit result block and drives `uart_send` one byte at a time through its `start` / `tx_rdy` handshake. Partial receive blocks are discarded after an idle timeout, so a lost byte cannot misalign every following block.

## Interface
- `TIMEOUT_CYCLES`, default 10416*40: idle `clk` cycles after the last received byte before a partial block is dropped (about 4 byte times at 9600 baud); must be at least 2.
- `clk` input 1: system clock, 100 MHz.
- `rst` input 1: asynchronous, active-low reset.
- `rx_byte` input 8: byte from `uart_recv`; valid only while `rx_done` = 1.
- `rx_done` input 1: single-cycle byte strobe from `uart_recv`.
- `blk_out` output 64: assembled block.
- `blk_out_valid` output 1: `blk_out` holds an unconsumed block.
- `blk_out_ready` input 1: consumer accepts the block.
- `blk_in` input 64: block to transmit.
- `blk_in_valid` input 1: `blk_in` is valid.
- `blk_in_ready` output 1: transmitter idle and able to latch `blk_in`.
- `tx_byte` output 8: byte to `uart_send` (`din`).
- `tx_start` output 1: one-cycle pulse to `uart_send` (`start`).
- `tx_rdy` input 1: `uart_send` ready.
- `rx_overrun` output 1: sticky; a completing byte was dropped.
- `rx_timeout` output 1: sticky; a partial block was dropped.
- `err_clr` input 1: synchronous clear of both sticky flags.

## Operation
Byte order is big-endian on both sides: the first byte on the wire maps to bits [63:56], and the eighth byte maps to [7:0].

**Receive assembler**
- State is a 3-bit `rx_cnt` (0..7), a 56-bit shift register `asm`, and a 32-bit idle counter `idle`.
- On `rx_done` with `rx_cnt` < 7: shift `rx_byte` into `asm`, increment `rx_cnt`, zero `idle`.
- On `rx_done` with `rx_cnt` = 7, when the output register is free (`!blk_out_valid`, or `blk_out_valid && blk_out_ready` in the same cycle):
  - load `blk_out` = {`asm`, `rx_byte`};
  - set `blk_out_valid`;
  - set `rx_cnt` to 0.
- On `rx_done` with `rx_cnt` = 7 and the output register not free: drop the byte, set `rx_overrun`, keep `rx_cnt` at 7 and keep `asm`.
- On a handshake with no new load: clear `blk_out_valid`. `blk_out` stays stable while `blk_out_valid` = 1.
- Timeout:
  - `idle` increments every cycle while `rx_cnt` != 0 and `rx_done` = 0.
  - When `idle` reaches `TIMEOUT_CYCLES - 1`: set `rx_cnt` to 0, set `idle` to 0, set `rx_timeout`.
  - A byte arriving in that same cycle takes priority: no timeout, and the byte is shifted in.
- `err_clr` clears both flags. A set event in the same cycle wins.

**Transmit serializer** (FSM)
- `TX_IDLE`: `blk_in_ready` = 1. On `blk_in_valid`, latch `blk_in` into `tx_sr`, set `tx_idx` = 0, go to `TX_LOAD`.
- `TX_LOAD`: `tx_byte` = `tx_sr[63:56]`. When `tx_rdy` = 1, pulse `tx_start` for one cycle and go to `TX_ACK`.
- `TX_ACK`: wait for `tx_rdy` = 0, then go to `TX_WAIT`.
- `TX_WAIT`: wait for `tx_rdy` = 1. Then:
  - if `tx_idx` = 7, go to `TX_IDLE`;
  - otherwise shift `tx_sr` left by 8, increment `tx_idx`, go to `TX_LOAD`.
- `tx_byte` is held constant from `TX_LOAD` entry until the FSM leaves `TX_WAIT`.

**Reset** (asynchronous, while `rst` = 0)
- `blk_out` = 0, `blk_out_valid` = 0, `blk_in_ready` = 0, `tx_byte` = 0, `tx_start` = 0, `rx_overrun` = 0, `rx_timeout` = 0.
- `rx_cnt` = 0, `idle` = 0, FSM = `TX_IDLE`.
- `blk_in_ready` rises on the first clock edge after release.
- A reset mid-block discards the partial receive and any in-flight transmit block.

## Timing
- All outputs are registered.
- Receive: the eighth `rx_done` at edge N gives `blk_out_valid` = 1 after edge N.
- Transmit: `blk_in_valid && blk_in_ready` at edge N gives `TX_LOAD` after edge N. `tx_start` is high for exactly one cycle, after the first edge at which `TX_LOAD` sees `tx_rdy` = 1.
- `tx_start` never re-asserts before `tx_rdy` has been observed low and then high again. This guarantees a fresh rising edge for `uart_send`.
- Per-block transmit time is 8 × (`uart_send` frame time + 3) cycles.
- Receive and transmit paths are fully independent and may run concurrently.

## Test plan
- Reset released, then bytes 01 02 03 04 05 06 07 08 on `rx_done` with `blk_out_ready` = 1 -> `blk_out` = 64'h0102030405060708, `blk_out_valid` high exactly one cycle, both flags 0.
- `blk_out_ready` = 0 and 16 bytes 00..0F -> first block 64'h0001020304050607 is held, byte 0F is dropped, `rx_overrun` = 1. Then raise ready, send byte AA -> next block is 64'h08090A0B0C0D0EAA.
- Bytes 11 22 33, silence for `TIMEOUT_CYCLES` (set to 100), then 8 bytes A0..A7 -> `rx_timeout` = 1, block = 64'hA0A1A2A3A4A5A6A7. `err_clr` pulse -> flag returns to 0.
- `blk_in` = 64'hDEADBEEF01234567 with a `uart_send` model (`DIVIDER` 4) -> exactly 8 `tx_start` pulses with bytes DE AD BE EF 01 23 45 67. `blk_in_ready` is low throughout and returns high after the last byte.
- Loopback `tx` to `rx` through real `uart_send` / `uart_recv`, sending 64'h0123456789ABCDEF -> identical `blk_out`, no flags set.
- Assert `rst` low during the 4th transmitted byte and after the 5th received byte -> all outputs are zero immediately. After release, a fresh 8-byte receive assembles correctly.
